// File: rtl/spi_pkg.sv
// Shared types for the SPI master: controller phases and the four {cpol,cpha} modes.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timebase: a one-cycle tick every CLK_DIV enabled cycles, restartable by clr_i.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/spi_master.sv
// Full-duplex SPI master: IDLE->SETUP->XFER->HOLD controller with runtime CPOL/CPHA,
// parametrised frame width, bit order and number of chip selects.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned CS_NUM    = 1,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DATA_W-1:0]       tx_data,
  input  logic [$clog2(CS_NUM):0] cs_sel,
  input  logic                    cpol,
  input  logic                    cpha,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [DATA_W-1:0]       rx_data,
  output logic                    spi_clk,
  output logic                    spi_mosi,
  input  logic                    spi_miso,
  output logic [CS_NUM-1:0]       spi_cs_n
);

  localparam int unsigned CSW = $clog2(CS_NUM) + 1;
  localparam int unsigned HPW = $clog2(2 * DATA_W) + 1;
  localparam logic [HPW-1:0] HP_LAST  = HPW'(2 * DATA_W - 1);
  localparam logic [CSW-1:0] CS_LIMIT = CSW'(CS_NUM);

  spi_state_e state_q, state_d;

  logic              tick;
  logic              accept, reject, sample, shift, finish, xfer_tick;
  logic [1:0]        mode_q;
  logic              sclk_q, mosi_q, done_q, err_q;
  logic [DATA_W-1:0] tx_q, rx_sr_q, rx_q;
  logic [HPW-1:0]    hp_q;
  logic [CS_NUM-1:0] cs_n_q, cs_dec;

  function automatic logic head_bit(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
    return MSB_FIRST ? {v[DATA_W-2:0], b} : {b, v[DATA_W-1:1]};
  endfunction

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (accept),
    .en_i  (busy),
    .tick_o(tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   if (tick) state_d = XFER;
      XFER:    if (tick && (hp_q == HP_LAST)) state_d = HOLD;
      HOLD:    if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Even half-period index = leading edge; the final trailing edge shifts nothing so mosi holds.
  always_comb begin
    busy      = (state_q != IDLE);
    accept    = 1'b0;
    reject    = 1'b0;
    sample    = 1'b0;
    shift     = 1'b0;
    xfer_tick = (state_q == XFER) && tick;
    finish    = (state_q == HOLD) && tick;
    if ((state_q == IDLE) && start) begin
      if (cs_sel < CS_LIMIT) accept = 1'b1;
      else                   reject = 1'b1;
    end
    if (xfer_tick) begin
      if (!hp_q[0]) begin
        sample = (mode_q == MODE0) || (mode_q == MODE2);
        shift  = (mode_q == MODE1) || (mode_q == MODE3);
      end else begin
        sample = (mode_q == MODE1) || (mode_q == MODE3);
        shift  = ((mode_q == MODE0) || (mode_q == MODE2)) && (hp_q != HP_LAST);
      end
    end
  end

  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < CS_NUM; i++) begin
      if (cs_sel == CSW'(i)) cs_dec[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      tx_q    <= '0;
      rx_sr_q <= '0;
      rx_q    <= '0;
      hp_q    <= '0;
      cs_n_q  <= '1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= finish;
      err_q  <= reject;
      if (accept) begin
        mode_q <= {cpol, cpha};
        sclk_q <= cpol;
        hp_q   <= '0;
        cs_n_q <= cs_dec;
        if (cpha) begin
          tx_q <= tx_data;
        end else begin
          mosi_q <= head_bit(tx_data);
          tx_q   <= advance(tx_data);
        end
      end
      if (xfer_tick) begin
        sclk_q <= ~sclk_q;
        hp_q   <= hp_q + HPW'(1);
      end
      if (shift) begin
        mosi_q <= head_bit(tx_q);
        tx_q   <= advance(tx_q);
      end
      if (sample) rx_sr_q <= shift_in(rx_sr_q, spi_miso);
      if (finish) begin
        rx_q   <= rx_sr_q;
        cs_n_q <= '1;
      end
    end
  end

  assign done     = done_q;
  assign err      = err_q;
  assign rx_data  = rx_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: modes 0/1/3, held start, chip selects, bad select,
// reset abort and LSB-first order on a second instance.
module tb_spi_master;
  import spi_pkg::*;

  localparam int LAT = 73;

  typedef struct {
    logic [7:0] rx;
    int         startCycle;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic       start = 1'b0;
  logic [7:0] txData = 8'h00;
  logic [2:0] csSel = 3'd0;
  logic       cpol = 1'b0, cpha = 1'b0;
  logic       busy, done, err, spiClk, spiMosi, spiMiso;
  logic [7:0] rxData;
  logic [3:0] spiCsN;
  logic       loopBack = 1'b1;

  logic       start2 = 1'b0;
  logic [7:0] txData2 = 8'h00;
  logic       csSel2 = 1'b0;
  logic       cpol2 = 1'b0, cpha2 = 1'b0;
  logic       busy2, done2, err2, spiClk2, spiMosi2, csN2;
  logic [7:0] rxData2;

  exp_t sbQ[$];
  exp_t sbQ2[$];
  logic leadQ[$];
  logic leadQ2[$];
  bit   captureOn = 1'b0, captureOn2 = 1'b0;
  logic prevClk = 1'b0, prevClk2 = 1'b0;

  int cycle = 0;
  int errors = 0, checks = 0;
  int doneCount = 0, errCount = 0, err2Count = 0;
  int doneBefore;

  assign spiMiso = loopBack ? spiMosi : 1'b1;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  spi_master #(
    .DATA_W(8), .CLK_DIV(4), .CS_NUM(4), .MSB_FIRST(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(txData), .cs_sel(csSel),
    .cpol(cpol), .cpha(cpha), .busy(busy), .done(done), .err(err), .rx_data(rxData),
    .spi_clk(spiClk), .spi_mosi(spiMosi), .spi_miso(spiMiso), .spi_cs_n(spiCsN)
  );

  spi_master #(
    .DATA_W(8), .CLK_DIV(4), .CS_NUM(1), .MSB_FIRST(1'b0)
  ) dutLsb (
    .clk(clk), .rst_n(rst_n), .start(start2), .tx_data(txData2), .cs_sel(csSel2),
    .cpol(cpol2), .cpha(cpha2), .busy(busy2), .done(done2), .err(err2), .rx_data(rxData2),
    .spi_clk(spiClk2), .spi_mosi(spiMosi2), .spi_miso(spiMosi2), .spi_cs_n(csN2)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endtask

  // Called at a negedge; leaves start high for one cycle and pushes the expected frame.
  task automatic applyStimulus(input logic [7:0] tx, input logic [2:0] cs,
                               input logic [1:0] mode, input logic [7:0] expRx,
                               input bit pushExp);
    exp_t e;
    txData = tx;
    csSel  = cs;
    {cpol, cpha} = mode;
    start  = 1'b1;
    if (pushExp) begin
      e.rx = expRx;
      e.startCycle = cycle;
      sbQ.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((sbQ.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain within budget", 32'(n < budget), 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      doneCount++;
      if (sbQ.size() == 0) begin
        checkOutput("unexpected done", 1, 0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("rx_data", rxData, e.rx);
        checkOutput("start to done latency", cycle - e.startCycle, LAT);
        checkOutput("busy in done cycle", busy, 0);
        checkOutput("cs released at done", spiCsN, 4'hF);
      end
    end
    if (err === 1'b1) errCount++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done2 === 1'b1) begin
      if (sbQ2.size() == 0) begin
        checkOutput("lsb unexpected done", 1, 0);
      end else begin
        e = sbQ2.pop_front();
        checkOutput("lsb rx_data", rxData2, e.rx);
        checkOutput("lsb latency", cycle - e.startCycle, LAT);
      end
    end
    if (err2 === 1'b1) err2Count++;
  end

  // Leading edge = spi_clk leaving its idle level; mosi is read after both have settled.
  always @(negedge clk) begin
    if (captureOn && prevClk == cpol && spiClk != cpol) leadQ.push_back(spiMosi);
    prevClk = spiClk;
    if (captureOn2 && prevClk2 == cpol2 && spiClk2 != cpol2) leadQ2.push_back(spiMosi2);
    prevClk2 = spiClk2;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] expLead;
    int n;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset err", err, 0);
    checkOutput("reset rx_data", rxData, 8'h00);
    checkOutput("reset spi_clk", spiClk, 0);
    checkOutput("reset spi_mosi", spiMosi, 0);
    checkOutput("reset spi_cs_n", spiCsN, 4'hF);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] mode 0 loopback 0xA5");
    loopBack = 1'b1;
    applyStimulus(8'hA5, 3'd0, MODE0, 8'hA5, 1'b1);
    repeat (30) @(negedge clk);
    checkOutput("cs0 low mid transfer", spiCsN, 4'hE);
    checkOutput("busy mid transfer", busy, 1);
    waitDrain(200);

    $display("[TB] mode 3, miso tied high, 0x3C");
    loopBack = 1'b0;
    leadQ.delete();
    captureOn = 1'b1;
    applyStimulus(8'h3C, 3'd1, MODE3, 8'hFF, 1'b1);
    waitDrain(200);
    captureOn = 1'b0;
    expLead = 8'h3C;
    checkOutput("mode3 leading edge count", leadQ.size(), 8);
    for (int i = 0; i < 8 && i < leadQ.size(); i++)
      checkOutput($sformatf("mode3 mosi bit %0d", i), leadQ[i], expLead[7-i]);
    repeat (3) @(negedge clk);
    checkOutput("idle spi_clk at latched cpol", spiClk, 1);
    checkOutput("mosi holds last bit", spiMosi, 0);

    $display("[TB] start held through a transfer");
    loopBack = 1'b1;
    txData = 8'h5A;
    csSel = 3'd3;
    {cpol, cpha} = MODE0;
    start = 1'b1;
    sbQ.push_back('{rx: 8'h5A, startCycle: cycle});
    sbQ.push_back('{rx: 8'h5A, startCycle: cycle + 73});
    doneBefore = doneCount;
    repeat (73) @(negedge clk);
    checkOutput("busy low in done cycle", busy, 0);
    @(negedge clk);
    checkOutput("held start re-accepted", busy, 1);
    start = 1'b0;
    waitDrain(300);
    checkOutput("held start done count", doneCount - doneBefore, 2);

    $display("[TB] chip select 2 and bad selects");
    applyStimulus(8'hC3, 3'd2, MODE0, 8'hC3, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("only cs2 low", spiCsN, 4'b1011);
    applyStimulus(8'h00, 3'd5, MODE0, 8'h00, 1'b0);
    waitDrain(200);
    applyStimulus(8'h11, 3'd5, MODE2, 8'h00, 1'b0);
    checkOutput("err pulse on bad select", err, 1);
    checkOutput("busy after bad select", busy, 0);
    @(negedge clk);
    checkOutput("err lasts one cycle", err, 0);
    repeat (4) @(negedge clk);
    checkOutput("busy stays low after bad select", busy, 0);
    checkOutput("cs idle after bad select", spiCsN, 4'hF);
    checkOutput("rejected start keeps cpol", spiClk, 0);

    $display("[TB] reset during transfer");
    applyStimulus(8'h96, 3'd1, MODE2, 8'h00, 1'b0);
    repeat (29) @(negedge clk);
    checkOutput("cs1 low before abort", spiCsN, 4'b1101);
    checkOutput("spi_clk high before abort", spiClk, 1);
    doneBefore = doneCount;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort spi_cs_n", spiCsN, 4'hF);
    checkOutput("abort spi_clk", spiClk, 0);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort rx_data cleared", rxData, 8'h00);
    checkOutput("abort spi_mosi", spiMosi, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (90) @(negedge clk);
    checkOutput("no done after abort", doneCount - doneBefore, 0);

    $display("[TB] LSB-first mode 1 loopback 0x81");
    leadQ2.delete();
    captureOn2 = 1'b1;
    txData2 = 8'h81;
    csSel2 = 1'b0;
    {cpol2, cpha2} = MODE1;
    start2 = 1'b1;
    sbQ2.push_back('{rx: 8'h81, startCycle: cycle});
    @(negedge clk);
    start2 = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("lsb cs low mid transfer", csN2, 0);
    n = 0;
    while ((sbQ2.size() != 0 || busy2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("lsb drain within budget", 32'(n < 200), 1);
    captureOn2 = 1'b0;
    expLead = 8'h81;
    checkOutput("lsb leading edge count", leadQ2.size(), 8);
    for (int i = 0; i < 8 && i < leadQ2.size(); i++)
      checkOutput($sformatf("lsb mosi bit %0d", i), leadQ2[i], expLead[i]);

    checkOutput("total err pulses", errCount, 1);
    checkOutput("lsb err pulses", err2Count, 0);
    checkOutput("scoreboard empty", sbQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
